store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores; power of two, >= 2.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, width of Count.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port MemWrite, input, 1: core store request this cycle.
REQ-006 SHALL have port DataAddr, input, 32: store byte address from core.
REQ-007 SHALL have port WriteData, input, 32: store data from core.
REQ-008 SHALL have port LoadAddr, input, 32: core load address for the forwarding lookup.
REQ-009 SHALL have port LoadHit, output, 1: a buffered store matches LoadAddr.
REQ-010 SHALL have port LoadData, output, 32: data of the youngest matching store.
REQ-011 SHALL have port StallSB, output, 1: buffer full; core must hold the store.
REQ-012 SHALL have port BusValid, output, 1: head store presented to memory.
REQ-013 SHALL have port BusAddr, output, 32: head store address.
REQ-014 SHALL have port BusData, output, 32: head store data.
REQ-015 SHALL have port BusReady, input, 1: memory accepts the head store this cycle.
REQ-016 SHALL have port Empty, output, 1: no entries held.
REQ-017 SHALL have port Count, output, CW: number of valid entries, 0..DEPTH.

Function
REQ-018 SHALL be a circular FIFO of DEPTH {addr[31:0], data[31:0]} entries, with head/tail pointers that wrap modulo DEPTH.
REQ-019 SHALL set StallSB = (Count == DEPTH), driven from registered state only, with no combinational path from BusReady or MemWrite.
REQ-020 SHALL enqueue {DataAddr, WriteData} at tail on MemWrite && !StallSB, with the tail advancing 1.
REQ-021 SHALL ignore MemWrite while StallSB is 1: no entry written, no pointer change. The core re-presents the store.
REQ-022 SHALL set BusValid = !Empty, BusAddr = head.addr, BusData = head.data.
REQ-023 SHALL dequeue on BusValid && BusReady, with the head advancing 1. BusReady with BusValid=0 has no effect.
REQ-024 SHALL hold BusAddr/BusData stable while BusValid=1 and BusReady=0.
REQ-025 SHALL keep Count unchanged on a simultaneous accepted enqueue and dequeue. The enqueue is refused when Count==DEPTH even if a dequeue occurs in the same cycle.
REQ-026 SHALL make an enqueue into an empty buffer visible on BusValid the following cycle; minimum store latency 1 cycle.
REQ-027 SHALL compute LoadHit combinationally: some valid entry has addr[31:2] == LoadAddr[31:2].
REQ-028 SHALL drive LoadData from the youngest (closest to tail) matching valid entry, and 0 when LoadHit=0.
REQ-029 SHALL exclude from the lookup a store being enqueued in the same cycle. SHALL include in the lookup an entry being dequeued in the same cycle.
REQ-030 SHALL keep stores in program order, with no coalescing and no reordering.
REQ-031 SHALL set Empty = (Count == 0).

Reset
REQ-032 SHALL, on rst=1 at a rising edge, set head=0, tail=0, Count=0, which gives Empty=1, BusValid=0, StallSB=0, LoadHit=0.
REQ-033 SHALL discard all pending entries when reset is asserted mid-operation; no bus handshake completes in that cycle.
REQ-034 SHALL ignore MemWrite during the reset cycle.
REQ-035 SHALL NOT require entry storage contents to be reset; only pointers and Count.

Verification
REQ-036 SHALL cover: after reset, one store A=0x100 D=0xDEADBEEF with BusReady=1 -> BusValid=1 next cycle with that addr/data; Empty=1 the cycle after.
REQ-037 SHALL cover: BusReady=0, 4 consecutive stores -> Count=4, StallSB=1. A 5th MemWrite -> ignored, Count stays 4. Then BusReady=1 -> drains in order over 4 cycles.
REQ-038 SHALL cover: full buffer, MemWrite and BusReady both 1 -> dequeue only, Count=3, StallSB=0 next cycle.
REQ-039 SHALL cover: Count=2, MemWrite and BusReady both 1 for 6 cycles -> Count stays 2, order preserved across pointer wrap.
REQ-040 SHALL cover: stores 0x200=0x11 then 0x200=0x22 buffered, LoadAddr=0x202 -> LoadHit=1, LoadData=0x22. LoadAddr=0x204 -> LoadHit=0, LoadData=0.
REQ-041 SHALL cover: rst=1 with 3 entries pending -> next cycle Count=0, BusValid=0, and LoadHit=0 for the previous addresses.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Circular FIFO of pending core stores. It drains in program order
//            to memory through a valid/ready bus, and forwards the youngest
//            matching word to loads.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemWrite,
    input  logic [31:0]   DataAddr,
    input  logic [31:0]   WriteData,
    input  logic [31:0]   LoadAddr,
    output logic          LoadHit,
    output logic [31:0]   LoadData,
    output logic          StallSB,
    output logic          BusValid,
    output logic [31:0]   BusAddr,
    output logic [31:0]   BusData,
    input  logic          BusReady,
    output logic          Empty,
    output logic [CW-1:0] Count
);

    localparam int            c_PTR_W = $clog2(DEPTH);
    localparam logic [CW-1:0] c_FULL  = CW'(DEPTH);

    logic [31:0]        r_addrMem [DEPTH];
    logic [31:0]        r_dataMem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [CW-1:0]      r_count;

    logic               w_full;
    logic               w_enq;
    logic               w_deq;
    logic               w_loadHit;
    logic [31:0]        w_loadData;
    logic [c_PTR_W-1:0] w_idx;
    logic               w_unusedLoadLsb;

    // Full and empty come straight from the registered count, so the stall
    // has no path from BusReady or MemWrite.
    assign w_full = (r_count == c_FULL);
    assign w_enq  = MemWrite && !w_full && !rst;
    assign w_deq  = (r_count != '0) && BusReady && !rst;

    assign StallSB  = w_full;
    assign Empty    = (r_count == '0);
    assign Count    = r_count;
    assign BusValid = (r_count != '0);
    assign BusAddr  = r_addrMem[r_head];
    assign BusData  = r_dataMem[r_head];
    assign LoadHit  = w_loadHit;
    assign LoadData = w_loadData;

    // The lookup compares word addresses only.
    assign w_unusedLoadLsb = ^LoadAddr[1:0];

    // Entry storage: written at the tail on an accepted store. It is not reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addrMem[r_tail] <= DataAddr;
            r_dataMem[r_tail] <= WriteData;
        end
    end

    // Pointers and occupancy. Reset discards every pending entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Forwarding lookup. Entries are walked oldest to youngest, so the last
    // match wins. The head entry takes part even while it is being dequeued.
    always_comb begin
        w_loadHit  = 1'b0;
        w_loadData = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + c_PTR_W'(k);
            if ((CW'(k) < r_count) && (r_addrMem[w_idx][31:2] == LoadAddr[31:2])) begin
                w_loadHit  = 1'b1;
                w_loadData = r_dataMem[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Self-checking bench for store_buffer. It keeps a queue-based
//            reference model, runs directed scenarios and then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          MemWrite;
    logic [31:0]   DataAddr;
    logic [31:0]   WriteData;
    logic [31:0]   LoadAddr;
    logic          LoadHit;
    logic [31:0]   LoadData;
    logic          StallSB;
    logic          BusValid;
    logic [31:0]   BusAddr;
    logic [31:0]   BusData;
    logic          BusReady;
    logic          Empty;
    logic [CW-1:0] Count;

    store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .DataAddr  (DataAddr),
        .WriteData (WriteData),
        .LoadAddr  (LoadAddr),
        .LoadHit   (LoadHit),
        .LoadData  (LoadData),
        .StallSB   (StallSB),
        .BusValid  (BusValid),
        .BusAddr   (BusAddr),
        .BusData   (BusData),
        .BusReady  (BusReady),
        .Empty     (Empty),
        .Count     (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reference model holds pending stores oldest-first as {addr, data}.
    logic [63:0] r_model [$];
    int          r_checks;
    int          r_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compares every DUT output with what the model says it must be right now.
    task automatic compare_model();
        logic        hit;
        logic [31:0] data;
        hit  = 1'b0;
        data = 32'h0;
        for (int i = r_model.size() - 1; i >= 0; i--) begin
            if (r_model[i][63:34] == LoadAddr[31:2]) begin
                hit  = 1'b1;
                data = r_model[i][31:0];
                break;
            end
        end
        chk("Count",    32'(Count),    32'(r_model.size()));
        chk("Empty",    32'(Empty),    32'(r_model.size() == 0));
        chk("StallSB",  32'(StallSB),  32'(r_model.size() == DEPTH));
        chk("BusValid", 32'(BusValid), 32'(r_model.size() != 0));
        if (r_model.size() != 0) begin
            chk("BusAddr", BusAddr, r_model[0][63:32]);
            chk("BusData", BusData, r_model[0][31:0]);
        end
        chk("LoadHit",  32'(LoadHit),  32'(hit));
        chk("LoadData", LoadData,      data);
    endtask

    // One clock cycle: drive the inputs, check against the model, take the
    // edge, then apply the same rules to the model. Returns at the next negedge.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] la, input logic br, input logic r);
        bit full;
        bit deq;
        bit enq;
        MemWrite  = mw;
        DataAddr  = a;
        WriteData = d;
        LoadAddr  = la;
        BusReady  = br;
        rst       = r;
        #1;
        compare_model();
        @(posedge clk);
        if (r) begin
            r_model.delete();
        end else begin
            full = (r_model.size() == DEPTH);
            deq  = (r_model.size() != 0) && br;
            enq  = mw && !full;
            if (deq) void'(r_model.pop_front());
            if (enq) r_model.push_back({a, d});
        end
        @(negedge clk);
    endtask

    initial begin
        r_checks  = 0;
        r_errors  = 0;
        rst       = 1'b1;
        MemWrite  = 1'b0;
        DataAddr  = 32'h0;
        WriteData = 32'h0;
        LoadAddr  = 32'h0;
        BusReady  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(1'b1, 32'h40, 32'h1, 32'h40, 1'b0, 1'b1);
        chk("rst_Count",    32'(Count),    32'd0);
        chk("rst_Empty",    32'(Empty),    32'd1);
        chk("rst_BusValid", 32'(BusValid), 32'd0);
        chk("rst_StallSB",  32'(StallSB),  32'd0);
        chk("rst_LoadHit",  32'(LoadHit),  32'd0);

        // Single store with latency 1, then it drains.
        step(1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        chk("s1_BusValid", 32'(BusValid), 32'd1);
        chk("s1_BusAddr",  BusAddr,       32'h100);
        chk("s1_BusData",  BusData,       32'hDEADBEEF);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("s1_Empty",    32'(Empty),    32'd1);

        // Fill while the bus is stalled, and a fifth store gets ignored.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h10 + 32'(i * 4), 32'(i + 1), 32'h0, 1'b0, 1'b0);
        chk("fill_Count",   32'(Count),   32'd4);
        chk("fill_StallSB", 32'(StallSB), 32'd1);
        step(1'b1, 32'h99C, 32'h55, 32'h0, 1'b0, 1'b0);
        chk("fifth_Count",  32'(Count),   32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_BusAddr", BusAddr, 32'h10 + 32'(i * 4));
            chk("drain_BusData", BusData, 32'(i + 1));
            step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain_Empty", 32'(Empty), 32'd1);

        // When full, a store and an accept in the same cycle only dequeue.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h500 + 32'(i * 4), 32'hA0 + 32'(i), 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h600, 32'hBB, 32'h0, 1'b1, 1'b0);
        chk("fullboth_Count",   32'(Count),   32'd3);
        chk("fullboth_StallSB", 32'(StallSB), 32'd0);

        // Occupancy stays at 2 through simultaneous traffic across the wrap.
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h700 + 32'(i * 4), 32'hC0 + 32'(i), 32'h0, 1'b1, 1'b0);
            chk("wrap_Count", 32'(Count), 32'd2);
        end
        chk("wrap_BusAddr", BusAddr, 32'h710);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Forwarding picks the youngest matching store.
        step(1'b1, 32'h200, 32'h11, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h200, 32'h22, 32'h0, 1'b0, 1'b0);
        LoadAddr = 32'h202;
        #1;
        chk("fwd_LoadHit",  32'(LoadHit), 32'd1);
        chk("fwd_LoadData", LoadData,     32'h22);
        LoadAddr = 32'h204;
        #1;
        chk("miss_LoadHit",  32'(LoadHit), 32'd0);
        chk("miss_LoadData", LoadData,     32'h0);

        // Reset with three entries pending; the store in that cycle is ignored.
        step(1'b1, 32'h300, 32'h33, 32'h0, 1'b0, 1'b0);
        chk("pre_Count", 32'(Count), 32'd3);
        step(1'b1, 32'h200, 32'h44, 32'h202, 1'b1, 1'b1);
        LoadAddr = 32'h202;
        #1;
        chk("mid_rst_Count",    32'(Count),    32'd0);
        chk("mid_rst_BusValid", 32'(BusValid), 32'd0);
        chk("mid_rst_LoadHit",  32'(LoadHit),  32'd0);

        // Random traffic on a small address pool so forwarding hits often.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) < 60),
                 32'h3000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                 $urandom(),
                 32'h3000 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
